// File: rtl/fetch_stage_pkg.sv
// Shared constants for the PA-RISC instruction-fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          PC_INC           = 4;
    localparam int          RESET_PC_DEFAULT = 0;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures the fetched word and its PC, with hold and nullify.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               valid_out
);

    localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;

    // Flush beats stall here: a nullified slot must never be held as a real instruction.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_W;
            pc_d    = pc_in;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= NOP_W;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pc_out    = pc_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// PA-RISC fetch stage: PC/nPC pair with one-slot delayed branching feeding the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 32,
    parameter int RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               ifid_valid
);

    localparam logic [ADDR_W-1:0] PC_INC_W    = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] RESET_PC_W  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] RESET_NPC_W = RESET_PC_W + PC_INC_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic [ADDR_W-1:0] target_aligned;

    // Low target bits are simply dropped; misalignment is not trapped here.
    assign target_aligned = branch_target & ALIGN_MASK;

    // A taken branch only redirects nPC, so the delay-slot word at nPC is still fetched.
    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (!stall) begin
            pc_d  = npc_q;
            npc_d = branch_taken ? target_aligned : npc_q + PC_INC_W;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_PC_W;
            npc_q <= RESET_NPC_W;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign imem_addr = pc_q;

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .flush     (flush),
        .instr_in  (imem_data),
        .pc_in     (pc_q),
        .instr_out (ifid_instr),
        .pc_out    (ifid_pc),
        .valid_out (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, hand-written corner sequences, random run vs model.
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic        ifid_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_w [64];

    // Reference model state
    logic [7:0]  m_pc, m_npc, m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid;

    typedef struct {
        logic       stall;
        logic       flush;
        logic       br;
        logic [7:0] tgt;
        logic [7:0] exp_pc;
        logic       exp_valid;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t vecs [16];

    fetch_stage #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_valid    (ifid_valid)
    );

    assign imem_data = mem_w[imem_addr[7:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [7:0] w;
        w = {a[7:2], 2'b00};
        return {w, ~w, 8'h5A, w ^ 8'h3C};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 8'h00;
        m_npc   = 8'h04;
        m_ifpc  = 8'h00;
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    // Spec rules applied to the model for one rising edge
    task automatic model_edge(input logic s, input logic f, input logic b, input logic [7:0] t);
        if (f) begin
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_ifpc  = m_pc;
        end else if (!s) begin
            m_instr = word_at(m_pc);
            m_valid = 1'b1;
            m_ifpc  = m_pc;
        end
        if (!s) begin
            m_pc  = m_npc;
            m_npc = b ? (t & 8'hFC) : m_npc + 8'd4;
        end
    endtask

    // Drive inputs (called just after a negedge), take one rising edge, return at the next negedge
    task automatic step(input logic s, input logic f, input logic b, input logic [7:0] t);
        stall         = s;
        flush         = f;
        branch_taken  = b;
        branch_target = t;
        @(posedge clk);
        model_edge(s, f, b, t);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " imem_addr"},  {24'h0, imem_addr}, {24'h0, m_pc});
        check({tag, " ifid_instr"}, ifid_instr,         m_instr);
        check({tag, " ifid_pc"},    {24'h0, ifid_pc},   {24'h0, m_ifpc});
        check({tag, " ifid_valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
    endtask

    initial begin
        reset_n = 1'b0;
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        for (int i = 0; i < 64; i++) mem_w[i] = word_at(8'(i * 4));

        //             stall flush br  tgt    exp_pc valid exp_addr
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h04};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 8'h08};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 8'h0C};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h0C, 1'b1, 8'h10};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h43, 8'h10, 1'b1, 8'h14};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h14, 1'b1, 8'h40};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 8'h44};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 8'h44};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 8'h44};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h80, 8'h40, 1'b1, 8'h44};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h44, 1'b1, 8'h48};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h48, 1'b0, 8'h48};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h48, 1'b0, 8'h4C};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h20, 8'h4C, 1'b0, 8'h50};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h50, 1'b1, 8'h20};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 1'b1, 8'h24};

        do_reset();
        check("reset imem_addr",  {24'h0, imem_addr}, 32'h0);
        check("reset ifid_instr", ifid_instr, 32'h0);
        check("reset ifid_pc",    {24'h0, ifid_pc}, 32'h0);
        check("reset ifid_valid", {31'h0, ifid_valid}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt);
            check($sformatf("vec%0d imem_addr", i),  {24'h0, imem_addr}, {24'h0, vecs[i].exp_addr});
            check($sformatf("vec%0d ifid_pc", i),    {24'h0, ifid_pc},   {24'h0, vecs[i].exp_pc});
            check($sformatf("vec%0d ifid_valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].exp_valid});
            check($sformatf("vec%0d ifid_instr", i), ifid_instr,
                  vecs[i].exp_valid ? word_at(vecs[i].exp_pc) : 32'h0);
        end

        // Delayed branch taken while PC=4: fetch order 4, 8, 0x40, 0x44
        do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h40);
        check("t3 fetch0", {24'h0, ifid_pc}, 32'h04);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("t3 fetch1 delay slot", {24'h0, ifid_pc}, 32'h08);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("t3 fetch2 target", {24'h0, ifid_pc}, 32'h40);
        check("t3 target instr", ifid_instr, word_at(8'h40));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("t3 fetch3", {24'h0, ifid_pc}, 32'h44);

        // Address wrap FC -> 00, then an unaligned target 0x43 fetching 0x40
        do_reset();
        step(1'b0, 1'b0, 1'b1, 8'hF8);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("t6 ifid_pc F8", {24'h0, ifid_pc}, 32'hF8);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("t6 ifid_pc FC", {24'h0, ifid_pc}, 32'hFC);
        check("t6 imem_addr wrap", {24'h0, imem_addr}, 32'h00);
        step(1'b0, 1'b0, 1'b1, 8'h43);
        check("t6 ifid_pc 00", {24'h0, ifid_pc}, 32'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("t6 target aligned", {24'h0, ifid_pc}, 32'h40);
        check_model("t6 model");

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic s, f, b;
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 15);
            b = ($urandom_range(0, 99) < 20);
            step(s, f, b, 8'($urandom_range(0, 255)));
            check_model($sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of the run, between edges
        #2;
        reset_n = 1'b0;
        #1;
        check("t1 async imem_addr",  {24'h0, imem_addr}, 32'h0);
        check("t1 async ifid_instr", ifid_instr, 32'h0);
        check("t1 async ifid_pc",    {24'h0, ifid_pc}, 32'h0);
        check("t1 async ifid_valid", {31'h0, ifid_valid}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("t1 held imem_addr",  {24'h0, imem_addr}, 32'h0);
        check("t1 held ifid_valid", {31'h0, ifid_valid}, 32'h0);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_model("t1 first fetch");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
